spi_flash_arbiter: RTL and testbench
====================================

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 SHALL have parameter SCLK_HALF, default 2, SCLK half-period in clk cycles (legal 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state advances on posedge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports Req0/Req1  input  1  transaction request, per requester.
REQ-005 SHALL have ports Write0/Write1  input  1  1 = write byte, 0 = read byte.
REQ-006 SHALL have ports Adr0/Adr1  input  32  byte address.
REQ-007 SHALL have ports WData0/WData1  input  8  write data.
REQ-008 SHALL have ports Done0/Done1  output  1  one-cycle completion pulse.
REQ-009 SHALL have port RData  output  8  last read byte, shared by both requesters.
REQ-010 SHALL have port Busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have ports SCLK  output  1; CSn  output  1; MOSI  output  1; MISO  input  1; SPI mode 0 (CPOL=0, CPHA=0).

Function
REQ-012 SHALL implement states IDLE, SETUP, SHIFT, HOLD, GAP, DONE.
REQ-013 IDLE: when any Req is high, grant one requester, latch its Write/Adr/WData into a 48-bit shift register {Adr, Cmd, WData-or-0x00}, and go to SETUP.
REQ-014 Cmd SHALL be 0x02 for write and 0x01 for read; frame is sent MSB first: 32 address bits, 8 command bits, 8 data bits.
REQ-015 SETUP: CSn=0, SCLK=0, MOSI=frame bit 47, for SCLK_HALF cycles, then SHIFT.
REQ-016 SHIFT: 48 SCLK periods of 2*SCLK_HALF cycles, high half first; MOSI SHALL change only on the cycle SCLK falls.
REQ-017 For reads, MISO SHALL be sampled on the clk edge where SCLK rises during bits 40..47 and shifted MSB first into a receive register.
REQ-018 After the 48th falling edge: HOLD (CSn=0, SCLK=0, SCLK_HALF cycles), then GAP (CSn=1, SCLK_HALF cycles), then DONE.
REQ-019 DONE: one cycle, pulse Done of the granted requester; on reads, update RData from the receive register in the same cycle; then return to IDLE.
REQ-020 Done SHALL be asserted exactly 99*SCLK_HALF+2 clk cycles after the accepting edge.
REQ-021 Requester SHALL hold operands stable until Done; latched copies are used regardless.
REQ-022 Req still high in the cycle after Done SHALL be treated as a new request.
REQ-023 Req dropped before Done SHALL NOT abort the transaction.
REQ-024 RData SHALL hold its value across writes and until the next read completes.
REQ-025 Done0 and Done1 SHALL never be high in the same cycle.

Reset
REQ-026 resetn low SHALL immediately force IDLE, CSn=1, SCLK=0, MOSI=0, Done0=Done1=0, Busy=0, RData=0x00, and the round-robin pointer to requester 0.
REQ-027 Reset mid-transaction SHALL abort with no Done pulse; first request after release starts a fresh frame.

Configuration
REQ-028 Macro SPI_FLASH_ARB_RR_EN defined: round-robin; on simultaneous requests grant the requester not granted last (requester 0 after reset).
REQ-029 SPI_FLASH_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous requests.

Verification
REQ-030 Req0 write Adr0=5, WData0=0xA5 -> CSn low 48 SCLK periods, MOSI frame 0x00000005_02_A5, Done0 at cycle 200 (SCLK_HALF=2).
REQ-031 Then Req1 read Adr1=5 -> MOSI 0x00000005_01_00, RData=0xA5 with Done1; Done0 stays 0.
REQ-032 Req0 and Req1 high together, held for two transactions -> RR_EN: Done0 then Done1; no RR_EN: Done0 twice.
REQ-033 resetn low at SHIFT bit 20 -> CSn=1, SCLK=0 same cycle, no Done; next write to address 7 then read returns the written byte.
REQ-034 Back-to-back read, read at addresses 1,2 holding 0x3C,0xC3 -> RData 0x3C then 0xC3; CSn high at least SCLK_HALF cycles between frames.

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
//   Shares one SPI (mode 0) flash port between two requesters. Each
//   transaction is one 48-bit frame {Adr[31:0], Cmd[7:0], Data[7:0]} sent MSB
//   first. Cmd 0x02 writes WData, Cmd 0x01 reads one byte; on a read the last
//   8 bits of MISO are captured and presented on RData with the Done pulse.
//
//   Optional feature macro: SPI_FLASH_ARB_RR_EN
//     defined   : round-robin grant on simultaneous requests (requester 0
//                 first after reset)
//     undefined : fixed priority, requester 0 wins simultaneous requests
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   Req0/1, Write0/1       request and direction (1 = write) per requester
//   Adr0/1, WData0/1       byte address and write data per requester
//   Done0/1                one-cycle completion pulse per requester
//   RData                  last byte read (shared)
//   Busy                   transaction in progress
//   SCLK, CSn, MOSI, MISO  SPI pins
//   dbg_state_o            current FSM state encoding, for debug/checkers
//
// Handshake: a requester raises Req with operands stable; the operands are
// latched on the accepting edge and Req may drop at any time afterwards
// without aborting. Done marks completion; Req still high after Done is
// taken as a new request.
//
// All pin outputs are registered decodes of the FSM state, so the pins lag
// the internal state by one clock. This places Done exactly 99*SCLK_HALF+2
// clocks after the accepting edge.

module spi_flash_arbiter #(
    parameter int SCLK_HALF = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        Write0,
    input  logic        Write1,
    input  logic [31:0] Adr0,
    input  logic [31:0] Adr1,
    input  logic [7:0]  WData0,
    input  logic [7:0]  WData1,
    output logic        Done0,
    output logic        Done1,
    output logic [7:0]  RData,
    output logic        Busy,
    output logic        SCLK,
    output logic        CSn,
    output logic        MOSI,
    input  logic        MISO,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [5:0]  bit_q;
    logic        phase_q;     // 1 = SCLK high half of the current bit
    logic [47:0] shreg_q;
    logic [7:0]  rx_q;
    logic        gnt_q;       // requester owning the current transaction
    logic        wr_q;
    logic        done0_q, done1_q, busy_q, sclk_q, cs_n_q, mosi_q;
    logic [7:0]  rdata_q;

    // Grant selection; only meaningful while some Req is high.
    logic pick;
`ifdef SPI_FLASH_ARB_RR_EN
    logic prefer_q;           // requester to favour on a tie
    always_comb pick = (Req0 && Req1) ? prefer_q : Req1;
`else
    always_comb pick = !Req0;
`endif

    logic        sel_wr;
    logic [31:0] sel_adr;
    logic [7:0]  sel_wdata;
    logic [47:0] sel_frame;
    always_comb begin
        sel_wr    = pick ? Write1 : Write0;
        sel_adr   = pick ? Adr1   : Adr0;
        sel_wdata = pick ? WData1 : WData0;
        sel_frame = {sel_adr, (sel_wr ? 8'h02 : 8'h01), (sel_wr ? sel_wdata : 8'h00)};
    end

    logic in_frame;
    logic sclk_next;
    always_comb begin
        in_frame  = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
        sclk_next = (state_q == SHIFT) && phase_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            bit_q    <= 6'd0;
            phase_q  <= 1'b0;
            shreg_q  <= 48'd0;
            rx_q     <= 8'd0;
            gnt_q    <= 1'b0;
            wr_q     <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            rdata_q  <= 8'd0;
`ifdef SPI_FLASH_ARB_RR_EN
            prefer_q <= 1'b0;
`endif
        end else begin
            // Registered pin stage, decoded from the current state.
            cs_n_q  <= !in_frame;
            sclk_q  <= sclk_next;
            mosi_q  <= in_frame ? shreg_q[47] : 1'b0;
            busy_q  <= (state_q != IDLE);
            done0_q <= (state_q == DONE) && !gnt_q;
            done1_q <= (state_q == DONE) &&  gnt_q;
            if ((state_q == DONE) && !wr_q)
                rdata_q <= rx_q;
            // MISO is sampled on the very edge at which the SCLK pin rises.
            if (sclk_next && !sclk_q && (bit_q >= 6'd40))
                rx_q <= {rx_q[6:0], MISO};

            case (state_q)
                IDLE: begin
                    if (Req0 || Req1) begin
                        gnt_q   <= pick;
                        wr_q    <= sel_wr;
                        shreg_q <= sel_frame;
                        cnt_q   <= 8'd0;
`ifdef SPI_FLASH_ARB_RR_EN
                        prefer_q <= !pick;
`endif
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= 8'd0;
                        bit_q   <= 6'd0;
                        phase_q <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= 8'd0;
                        if (phase_q) begin
                            // End of high half: SCLK falls, next bit goes out.
                            phase_q <= 1'b0;
                            shreg_q <= {shreg_q[46:0], 1'b0};
                        end else if (bit_q == 6'd47) begin
                            state_q <= HOLD;
                        end else begin
                            bit_q   <= bit_q + 6'd1;
                            phase_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= 8'd0;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= 8'd0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Done0       = done0_q;
    assign Done1       = done1_q;
    assign RData       = rdata_q;
    assign Busy        = busy_q;
    assign SCLK        = sclk_q;
    assign CSn         = cs_n_q;
    assign MOSI        = mosi_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Testbench for spi_flash_arbiter: directed transactions against a small
// behavioural SPI flash (16 bytes, address low nibble), expected values
// computed by hand for SCLK_HALF = 2.

module tb_spi_flash_arbiter;

    localparam int H      = 2;
    localparam int T_DONE = 99 * H + 2;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [31:0] adr0 = '0, adr1 = '0;
    logic [7:0]  wd0 = '0, wd1 = '0;
    logic        done0, done1, busy, sclk, cs_n, mosi;
    logic        miso = 1'b0;
    logic [7:0]  rdata;
    logic [2:0]  dbg_state;

    spi_flash_arbiter #(.SCLK_HALF(H)) dut (
        .clk(clk), .resetn(resetn),
        .Req0(req0), .Req1(req1), .Write0(wr0), .Write1(wr1),
        .Adr0(adr0), .Adr1(adr1), .WData0(wd0), .WData1(wd1),
        .Done0(done0), .Done1(done1), .RData(rdata), .Busy(busy),
        .SCLK(sclk), .CSn(cs_n), .MOSI(mosi), .MISO(miso),
        .dbg_state_o(dbg_state)
    );

    // ---------------- flash model ----------------
    logic [7:0]  mem [0:15] = '{8'h00, 8'h3C, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [47:0] frame = '0, last_frame = '0;
    int          bitc = 0, last_bits = 0;
    logic [7:0]  rd_byte = '0, rd_cmd = '0;
    int          cyc = 0, t_fall = 0, t_rise = -1000, last_low = 0, min_gap = 1000;

    always @(posedge clk) cyc++;

    always @(negedge cs_n) begin
        if (cyc - t_rise < min_gap) min_gap = cyc - t_rise;
        t_fall = cyc;
    end

    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) begin
            t_rise     = cyc;
            last_low   = cyc - t_fall;
            last_frame = frame;
            last_bits  = bitc;
            if (bitc == 48 && frame[15:8] == 8'h02) mem[frame[19:16]] = frame[7:0];
            bitc  = 0;
            frame = '0;
        end else begin
            frame = {frame[46:0], mosi};
            bitc++;
        end
    end

    always @(negedge sclk) begin
        if (!cs_n) begin
            if (bitc == 40) begin
                rd_cmd  = frame[7:0];
                rd_byte = mem[frame[11:8]];
            end
            if (rd_cmd == 8'h01 && bitc >= 40 && bitc <= 47) miso = rd_byte[47 - bitc];
            else miso = 1'b0;
        end
    end

    // ---------------- pin monitors ----------------
    logic cs_p = 1'b1, sclk_p = 1'b0, mosi_p = 1'b0;
    int   mosi_bad = 0, both_bad = 0, d0_cnt = 0, d1_cnt = 0;
    always @(negedge clk) begin
        if (!cs_p && !cs_n && mosi !== mosi_p && !(sclk_p && !sclk)) mosi_bad++;
        if (done0 && done1) both_bad++;
        if (done0) d0_cnt++;
        if (done1) d1_cnt++;
        cs_p = cs_n; sclk_p = sclk; mosi_p = mosi;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_req(input int r, input logic w, input logic [31:0] a, input logic [7:0] d);
        if (r == 0) begin req0 = 1'b1; wr0 = w; adr0 = a; wd0 = d; end
        else        begin req1 = 1'b1; wr1 = w; adr1 = a; wd1 = d; end
    endtask

    // Called at a negedge with the DUT idle: the next posedge accepts. Returns
    // at the negedge of the Done cycle (cycle number relative to that edge).
    task automatic wait_done(output int c, output logic w0, output logic w1);
        c = -1; w0 = 1'b0; w1 = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 2 * T_DONE; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                c = i; w0 = done0; w1 = done1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    int   c, dsum;
    logic w0, w1;
    logic e0a, e1a, e0b, e1b;
    logic [7:0] ra, rb;

    initial begin
        // reset state
        #12;
        check("rst_csn", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_done", {done0, done1}, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk); resetn = 1'b1;
        repeat (2) @(negedge clk);

        // write 0xA5 to address 5 from requester 0
        start_req(0, 1'b1, 32'd5, 8'hA5);
        wait_done(c, w0, w1);
        check("t1_done_cycle", c, T_DONE);
        check("t1_done0", w0, 1);
        check("t1_done1", w1, 0);
        check("t1_busy", busy, 1);
        check("t1_rdata_hold", rdata, 8'h00);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_frame", last_frame, 48'h00000005_02_A5);
        check("t1_bits", last_bits, 48);
        check("t1_csn_low", last_low, 98 * H);
        check("t1_mem", mem[5], 8'hA5);
        check("t1_idle", busy, 0);

        // read address 5 from requester 1
        start_req(1, 1'b0, 32'd5, 8'hFF);
        exp_q.push_back(8'hA5);
        wait_done(c, w0, w1);
        check("t2_done_cycle", c, T_DONE);
        check("t2_done1", w1, 1);
        check("t2_done0", w0, 0);
        check("t2_rdata", rdata, exp_q.pop_front());
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("t2_frame", last_frame, 48'h00000005_01_00);
        check("t2_done0_count", d0_cnt, 1);

        // simultaneous requests held for two transactions
`ifdef SPI_FLASH_ARB_RR_EN
        e0a = 1'b1; e1a = 1'b0; ra = 8'h3C;
        e0b = 1'b0; e1b = 1'b1; rb = 8'hC3;
`else
        e0a = 1'b1; e1a = 1'b0; ra = 8'h3C;
        e0b = 1'b1; e1b = 1'b0; rb = 8'h3C;
`endif
        start_req(0, 1'b0, 32'd1, 8'h00);
        start_req(1, 1'b0, 32'd2, 8'h00);
        exp_q.push_back(ra);
        exp_q.push_back(rb);
        wait_done(c, w0, w1);
        check("t3_first_cycle", c, T_DONE);
        check("t3_first_who", {w0, w1}, {e0a, e1a});
        check("t3_first_rdata", rdata, exp_q.pop_front());
        wait_done(c, w0, w1);
        check("t3_second_cycle", c, T_DONE);
        check("t3_second_who", {w0, w1}, {e0b, e1b});
        check("t3_second_rdata", rdata, exp_q.pop_front());
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_idle_after", busy, 0);

        // back-to-back reads of addresses 1 and 2 from requester 0
        min_gap = 1000;
        start_req(0, 1'b0, 32'd1, 8'h00);
        exp_q.push_back(8'h3C);
        wait_done(c, w0, w1);
        check("t4_first_rdata", rdata, exp_q.pop_front());
        adr0 = 32'd2;
        exp_q.push_back(8'hC3);
        wait_done(c, w0, w1);
        check("t4_second_cycle", c, T_DONE);
        check("t4_second_rdata", rdata, exp_q.pop_front());
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_gap_ge_half", min_gap >= H, 1);
        check("t4_frame", last_frame, 48'h00000002_01_00);

        // reset in the middle of a write at bit 20
        start_req(0, 1'b1, 32'd3, 8'h77);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bitc >= 21) break;
        end
        check("t5_reached_bit20", bitc >= 21, 1);
        dsum = d0_cnt + d1_cnt;
        resetn = 1'b0; req0 = 1'b0;
        #1;
        check("t5_rst_csn", cs_n, 1);
        check("t5_rst_sclk", sclk, 0);
        check("t5_rst_mosi", mosi, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rdata", rdata, 8'h00);
        check("t5_rst_state", dbg_state, 0);
        repeat (3) @(negedge clk);
        check("t5_no_done", d0_cnt + d1_cnt, dsum);
        check("t5_no_write", mem[3], 8'h00);
        check("t5_aborted_frame", last_bits == 48, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        start_req(1, 1'b1, 32'd7, 8'h5A);
        wait_done(c, w0, w1);
        check("t5_write_cycle", c, T_DONE);
        check("t5_write_done1", w1, 1);
        check("t5_write_rdata_hold", rdata, 8'h00);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_write_frame", last_frame, 48'h00000007_02_5A);
        start_req(0, 1'b0, 32'd7, 8'h00);
        exp_q.push_back(8'h5A);
        wait_done(c, w0, w1);
        check("t5_read_done0", w0, 1);
        check("t5_read_rdata", rdata, exp_q.pop_front());
        req0 = 1'b0;
        repeat (3) @(negedge clk);

        // whole-run properties
        check("mosi_only_on_fall", mosi_bad, 0);
        check("never_both_done", both_bad, 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
